// File: rtl/cand_sel_pkg.sv
// Shared mode constants and FSM state encoding for the candidate selector.
package cand_sel_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/cand_slice_mux.sv
// Combinational N-to-1 slice select; out-of-range index yields zero.
// Latency: 0 cycles (pure combinational).
// Backpressure: none, caller registers the result.
module cand_slice_mux #(
    parameter int WIDTH = 128,
    parameter int N     = 16,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   slice
);

    // Compare against every legal index so non-power-of-two N needs no range check.
    always_comb begin
        slice = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) begin
                slice = in_bus[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/cand_select_scan.sv
// Registered N-to-1 candidate selector: direct indexed beats or full in-order scan.
// Latency: 1 cycle from accepted request to out_valid; scan streams one beat per cycle.
// Backpressure: out_ready low freezes the output register; requests held off via req_ready.
module cand_select_scan
    import cand_sel_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int N     = 16,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [N*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]   sel,
    input  logic               sel_valid,
    input  logic               start,
    output logic               req_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_idx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);

    state_t             state, state_nxt;
    logic               fire;
    logic               load;
    logic               done_nxt;
    logic [SEL_W-1:0]   load_idx;
    logic [WIDTH-1:0]   mux_dat;

    assign fire      = out_valid && out_ready;
    assign req_ready = (state == IDLE) && (!out_valid || out_ready);
    assign busy      = (state == SCAN);

    cand_slice_mux #(
        .WIDTH (WIDTH),
        .N     (N),
        .SEL_W (SEL_W)
    ) u_mux (
        .in_bus (in_bus),
        .sel    (load_idx),
        .slice  (mux_dat)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_idx  = sel;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (req_ready) begin
                    if (start && mode == MODE_SCAN) begin
                        state_nxt = SCAN;
                        load      = 1'b1;
                        load_idx  = '0;
                    end else if (sel_valid && mode == MODE_DIRECT) begin
                        load      = 1'b1;
                        load_idx  = sel;
                    end
                end
            end
            SCAN: begin
                if (fire) begin
                    if (out_idx == LAST_IDX) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        load      = 1'b1;
                        load_idx  = out_idx + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            if (load) begin
                out_data  <= mux_dat;
                out_idx   <= load_idx;
                out_valid <= 1'b1;
            end else if (fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cand_select_scan.sv
// Directed bench for cand_select_scan: N=16 instance plus an N=10 instance.
module tb_cand_select_scan;

    localparam int W  = 128;
    localparam int NA = 16;
    localparam int NB = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              mode, sel_valid, start, out_ready;
    logic [NA*W-1:0]   in_bus;
    logic [3:0]        sel;
    logic              req_ready, out_valid, busy, done;
    logic [W-1:0]      out_data;
    logic [3:0]        out_idx;

    logic              mode_b, sel_valid_b, start_b, out_ready_b;
    logic [NB*W-1:0]   in_bus_b;
    logic [3:0]        sel_b;
    logic              req_ready_b, out_valid_b, busy_b, done_b;
    logic [W-1:0]      out_data_b;
    logic [3:0]        out_idx_b;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    cand_select_scan #(.WIDTH(W), .N(NA)) dut_a (
        .clk(clk), .rst(rst), .mode(mode), .in_bus(in_bus), .sel(sel),
        .sel_valid(sel_valid), .start(start), .req_ready(req_ready),
        .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    cand_select_scan #(.WIDTH(W), .N(NB)) dut_b (
        .clk(clk), .rst(rst), .mode(mode_b), .in_bus(in_bus_b), .sel(sel_b),
        .sel_valid(sel_valid_b), .start(start_b), .req_ready(req_ready_b),
        .out_data(out_data_b), .out_idx(out_idx_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [W-1:0] cand(input int i);
        return 128'h100 + W'(i);
    endfunction

    // Full 16-beat scan with optional stall and an optional burst of requests while busy.
    task automatic scan_a(input int stall_at, input int stall_len, input int poke_at, input int exp_lat);
        int t0;
        int n;
        mode = 1'b1; start = 1'b1; out_ready = 1'b1;
        t0 = cyc;
        step();
        start = 1'b0;
        for (int i = 0; i < NA; i++) begin
            if (i == stall_at) begin
                out_ready = 1'b0;
                for (int k = 0; k < stall_len; k++) begin
                    chk("stall_idx", W'(out_idx), W'(i));
                    chk("stall_dat", out_data, cand(i));
                    chk("stall_vld", W'(out_valid), 1);
                    step();
                end
                out_ready = 1'b1;
            end
            chk("scan_vld",  W'(out_valid), 1);
            chk("scan_idx",  W'(out_idx), W'(i));
            chk("scan_dat",  out_data, cand(i));
            chk("scan_busy", W'(busy), 1);
            chk("scan_done_early", W'(done), 0);
            if (i == poke_at) begin
                mode = 1'b0; sel = 4'd3; sel_valid = 1'b1;
            end else if (i == poke_at + 1) begin
                mode = 1'b1; sel_valid = 1'b0; start = 1'b1;
            end else begin
                mode = 1'b1; sel_valid = 1'b0; start = 1'b0;
            end
            step();
        end
        start = 1'b0; sel_valid = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            step();
            n++;
        end
        chk("done_lat",   W'(cyc - t0), W'(exp_lat));
        chk("done_busy",  W'(busy), 0);
        chk("done_vld",   W'(out_valid), 0);
        chk("done_rdy",   W'(req_ready), 1);
        step();
        chk("done_pulse", W'(done), 0);
    endtask

    initial begin
        for (int i = 0; i < NA; i++) in_bus[i*W +: W] = cand(i);
        for (int i = 0; i < NB; i++) in_bus_b[i*W +: W] = cand(i);
        rst = 1'b1;
        mode = 1'b0; sel = '0; sel_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
        mode_b = 1'b0; sel_b = '0; sel_valid_b = 1'b0; start_b = 1'b0; out_ready_b = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_vld",  W'(out_valid), 0);
        chk("rst_dat",  out_data, 0);
        chk("rst_idx",  W'(out_idx), 0);
        chk("rst_busy", W'(busy), 0);
        chk("rst_done", W'(done), 0);
        chk("rst_rdy",  W'(req_ready), 1);

        // Direct back-to-back selects.
        mode = 1'b0; sel_valid = 1'b1; sel = 4'd2;
        step();
        chk("dir2_vld", W'(out_valid), 1);
        chk("dir2_idx", W'(out_idx), 2);
        chk("dir2_dat", out_data, 128'h102);
        sel = 4'd5;
        step();
        chk("dir5_idx", W'(out_idx), 5);
        chk("dir5_dat", out_data, 128'h105);
        sel = 4'd14;
        step();
        chk("dir14_idx", W'(out_idx), 14);
        chk("dir14_dat", out_data, 128'h10E);
        chk("dir14_busy", W'(busy), 0);
        sel_valid = 1'b0;
        step();
        chk("dir_clear", W'(out_valid), 0);

        // Direct beat under backpressure holds, then drains.
        out_ready = 1'b0; sel_valid = 1'b1; sel = 4'd7;
        step();
        sel = 4'd9;
        chk("hold_rdy", W'(req_ready), 0);
        step();
        chk("hold_idx", W'(out_idx), 7);
        chk("hold_dat", out_data, 128'h107);
        sel_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("hold_drain", W'(out_valid), 0);

        scan_a(-1, 0, -1, 17);
        scan_a(7, 3, -1, 20);
        scan_a(-1, 0, 4, 17);

        // Reset while idx 9 is presented.
        mode = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("mid_idx9", W'(out_idx), 9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_vld",  W'(out_valid), 0);
        chk("mrst_dat",  out_data, 0);
        chk("mrst_idx",  W'(out_idx), 0);
        chk("mrst_busy", W'(busy), 0);
        chk("mrst_done", W'(done), 0);
        step();
        chk("mrst_nodone", W'(done), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_idx",  W'(out_idx), 0);
        chk("restart_dat",  out_data, 128'h100);
        chk("restart_busy", W'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;

        // N=10 instance: out-of-range direct, last legal index, then full scan.
        mode_b = 1'b0; sel_valid_b = 1'b1; sel_b = 4'd12;
        step();
        chk("b_oor_idx", W'(out_idx_b), 12);
        chk("b_oor_dat", out_data_b, 0);
        chk("b_oor_vld", W'(out_valid_b), 1);
        sel_b = 4'd9;
        step();
        chk("b_9_dat", out_data_b, 128'h109);
        sel_valid_b = 1'b0; mode_b = 1'b1; start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i < NB; i++) begin
            chk("b_scan_idx", W'(out_idx_b), W'(i));
            chk("b_scan_dat", out_data_b, cand(i));
            step();
        end
        chk("b_done", W'(done_b), 1);
        chk("b_busy", W'(busy_b), 0);
        chk("b_vld",  W'(out_valid_b), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cand_select_scan.md
# cand_select_scan

Parametrised, registered N-to-1 selector for 128-bit AES state/key candidates with a valid/ready output stream. It supports two modes: direct indexed selection, and an automatic scan that streams every candidate in index order. It sits between the candidate-generation stage (round-key / partial-key guesses) and the key-check stage, and replaces the fixed 16-to-1 combinational mux.

## Interface
Parameters:
- `WIDTH`, 128, bits per candidate.
- `N`, 16, number of candidates; any value ≥ 2, not required to be a power of two.
- `SEL_W`, `$clog2(N)`, index width (derived; do not override).

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  1  0 = direct select, 1 = scan; sampled only when a request is accepted.
- `in_bus`  in  N*WIDTH  flattened candidates; candidate i = `in_bus[i*WIDTH +: WIDTH]`.
- `sel`  in  SEL_W  candidate index for a direct request.
- `sel_valid`  in  1  direct request (mode = 0).
- `start`  in  1  scan request (mode = 1).
- `req_ready`  out  1  request can be accepted this cycle.
- `out_data`  out  WIDTH  selected candidate.
- `out_idx`  out  SEL_W  index of `out_data`.
- `out_valid`  out  1  output register holds a beat.
- `out_ready`  in  1  downstream accepts the beat.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse after the final scan beat is accepted.

## Operation
- States are IDLE and SCAN. A beat "fires" when `out_valid && out_ready`.
- `req_ready = (state == IDLE) && (!out_valid || out_ready)`.
- Direct mode, IDLE: if `sel_valid && !mode && req_ready`, the output register loads the slice at `sel`, `out_idx <= sel`, `out_valid <= 1`. The state stays IDLE.
- Out-of-range index (`sel >= N`): `out_data` loads all zeros, `out_idx <= sel`, and the beat is still produced.
- Scan mode, IDLE: if `start && mode && req_ready`, go to SCAN and load candidate 0 with `out_idx = 0`.
- In SCAN, when a beat fires with `out_idx < N-1`, load candidate `out_idx+1`.
- In SCAN, when a beat fires with `out_idx == N-1`:
  - `out_valid <= 0`, state goes to IDLE, `done <= 1` for one cycle.
- Holding: while `out_valid && !out_ready`, `out_data` and `out_idx` stay frozen. No beat is dropped or duplicated.
- Output register clearing: clears when a beat fires and nothing new loads.
- Ignored inputs: `start` and `sel_valid` are ignored while `busy`; `sel_valid` is ignored when `mode = 1`; `start` is ignored when `mode = 0`.
- Input sampling: `in_bus` is sampled at each load. Upstream holds it stable while `busy`. A change mid-scan affects only the beats not yet loaded.
- Output semantics: `busy = (state == SCAN)`; `done` is registered.
- Reset (including mid-scan): next cycle state = IDLE, and `out_valid`, `out_data`, `out_idx`, `busy`, `done` are all 0. The interrupted scan is abandoned and produces no `done`.

## Timing
- Direct latency: request accepted in cycle t → `out_valid` in t+1.
- Direct back-to-back: with `out_ready` high, one beat per cycle.
- Scan with `out_ready` held high:
  - `start` in cycle t → beat i valid in cycle t+1+i.
  - Last beat (N-1) in cycle t+N.
  - `done` = 1 and `busy` = 0 in cycle t+N+1; `req_ready` is high in t+N+1.
- Backpressure: each cycle of `out_ready` low stretches the scan by exactly one cycle.
- `done` never asserts in the same cycle as `out_valid` from that scan.

## Structure
- Shared package `cand_sel_pkg` holds the mode constants (`MODE_DIRECT = 1'b0`, `MODE_SCAN = 1'b1`) and the state enum (IDLE, SCAN).
- One combinational sub-module, `cand_slice_mux`, parametrised on WIDTH/N: it outputs the indexed slice, or zero when out of range.
- FSM, counter and output register live in `cand_select_scan`.

## Test plan
All scenarios use WIDTH=128, N=16, and candidate i = `128'd i + 128'h100`.
- Direct: `sel=2`, then 5, then 14, `out_ready=1` → beats (idx,data) = (2,0x102), (5,0x105), (14,0x10E) in consecutive cycles, each one cycle after its request.
- Scan, no stall: `start` at cycle t → `out_idx` 0..15 in cycles t+1..t+16; `done` pulse at t+17; `busy` high in t+1..t+16.
- Scan, backpressure: `out_ready` low for 3 cycles while idx=7 is presented → idx 7 and data 0x107 held stable; no skip or repeat; `done` is 3 cycles later than in the no-stall case.
- Ignored request: `start` and `sel_valid` (`sel=3`) pulsed while `busy` → ignored; the beat sequence is unchanged.
- Reset mid-scan: `rst` at idx=9 → next cycle all outputs 0, state IDLE, no `done`. A new `start` then restarts at idx 0.
- Non-power-of-two: N=10 with `sel=12` → beat (12, 0). A scan emits idx 0..9, then `done`.
